// File: rtl/pio_bank_pkg.sv
// Shared constants and types for the Avalon-MM PIO bank: register offsets,
// per-channel address stride and the edge-detect selection.
package pio_bank_pkg;

    localparam int unsigned REG_STRIDE_LOG2 = 3;

    localparam logic [2:0] REG_DATA     = 3'd0;
    localparam logic [2:0] REG_IRQ_MASK = 3'd1;
    localparam logic [2:0] REG_EDGE_CAP = 3'd2;
    localparam logic [2:0] REG_OUT_SET  = 3'd4;
    localparam logic [2:0] REG_OUT_CLR  = 3'd5;

    typedef enum logic [1:0] {
        EDGE_RISING  = 2'd0,
        EDGE_FALLING = 2'd1,
        EDGE_ANY     = 2'd2
    } edge_type_e;

endpackage

// File: rtl/avalon_pio_bank_if.sv
// Avalon-MM slave bus bundle for the PIO bank; the fabric side drives the
// master modport, the bank consumes the slave modport.
interface avalon_pio_bank_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              avs_chipselect;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;

    modport master (
        output avs_chipselect, avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_chipselect, avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/pio_channel.sv
// One PIO channel. Input flavour: synchroniser, edge capture, IRQ mask.
// Output flavour: output register with atomic set/clear.
module pio_channel
    import pio_bank_pkg::*;
#(
    parameter bit          IS_INPUT    = 1'b0,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_pin,
    input  logic             i_wr_en,
    input  logic [2:0]       i_reg,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata_c,
    output logic [WIDTH-1:0] o_out,
    output logic             o_irq_c
);

    if (IS_INPUT) begin : g_in
        localparam edge_type_e ET = edge_type_e'(2'(EDGE_TYPE));

        logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
        logic [WIDTH-1:0] r_hist;
        logic [WIDTH-1:0] r_edge;
        logic [WIDTH-1:0] r_mask;
        logic [WIDTH-1:0] r_cap;
        logic [WIDTH-1:0] w_last;
        logic [WIDTH-1:0] w_edge;
        logic [WIDTH-1:0] w_clr;

        assign w_last = r_sync[SYNC_STAGES-1];
        assign w_clr  = (i_wr_en && i_reg == REG_EDGE_CAP) ? i_wdata : '0;

        // Edge between the last synchroniser stage and the history flop.
        always_comb begin
            w_edge = '0;
            case (ET)
                EDGE_RISING:  w_edge = w_last & ~r_hist;
                EDGE_FALLING: w_edge = ~w_last & r_hist;
                default:      w_edge = w_last ^ r_hist;
            endcase
        end

        // New edge is OR-ed after the W1C so a coincident event is never lost.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_sync <= '0;
                r_hist <= '0;
                r_edge <= '0;
                r_mask <= '0;
                r_cap  <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
                r_hist <= w_last;
                r_edge <= w_edge;
                r_cap  <= (r_cap & ~w_clr) | r_edge;
                if (i_wr_en && i_reg == REG_IRQ_MASK) begin
                    r_mask <= i_wdata;
                end
            end
        end

        always_comb begin
            o_rdata_c = '0;
            case (i_reg)
                REG_DATA:     o_rdata_c = w_last;
                REG_IRQ_MASK: o_rdata_c = r_mask;
                REG_EDGE_CAP: o_rdata_c = r_cap;
                default:      o_rdata_c = '0;
            endcase
        end

        assign o_out   = '0;
        assign o_irq_c = |(r_cap & r_mask);
    end else begin : g_out
        logic [WIDTH-1:0] r_out;
        logic             w_unused_pin;

        assign w_unused_pin = ^i_pin;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_out <= '0;
            end else if (i_wr_en) begin
                case (i_reg)
                    REG_DATA:    r_out <= i_wdata;
                    REG_OUT_SET: r_out <= r_out | i_wdata;
                    REG_OUT_CLR: r_out <= r_out & ~i_wdata;
                    default:     r_out <= r_out;
                endcase
            end
        end

        assign o_rdata_c = (i_reg == REG_DATA) ? r_out : '0;
        assign o_out     = r_out;
        assign o_irq_c   = 1'b0;
    end

endmodule

// File: rtl/avalon_pio_bank.sv
// Multi-channel Avalon-MM PIO bank: address decode, registered read data
// and a registered OR of all channel interrupt terms.
module avalon_pio_bank
    import pio_bank_pkg::*;
#(
    parameter int unsigned        NUM_CH      = 4,
    parameter int unsigned        WIDTH       = 16,
    parameter logic [NUM_CH-1:0]  CH_IS_INPUT = NUM_CH'(1),
    parameter int unsigned        EDGE_TYPE   = 0,
    parameter int unsigned        SYNC_STAGES = 2
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    avalon_pio_bank_if.slave        avs,
    output logic                    irq,
    input  logic [NUM_CH*WIDTH-1:0] pio_in,
    output logic [NUM_CH*WIDTH-1:0] pio_out
);

    localparam int unsigned ADDR_W = $clog2(NUM_CH) + REG_STRIDE_LOG2;
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [ADDR_W-1:0] w_addr;
    logic [CH_W-1:0]   w_ch;
    logic [2:0]        w_reg;
    logic              w_ch_ok;
    logic              w_wr;
    logic              w_rd;
    logic [WIDTH-1:0]  w_wdata;
    logic [WIDTH-1:0]  w_rdata [NUM_CH];
    logic [NUM_CH-1:0] w_irq;
    logic              w_unused_wd;

    assign w_addr      = avs.avs_address;
    assign w_ch        = CH_W'(w_addr >> REG_STRIDE_LOG2);
    assign w_reg       = w_addr[2:0];
    assign w_ch_ok     = (32'(w_ch) < NUM_CH);
    assign w_wr        = avs.avs_chipselect && avs.avs_write && w_ch_ok;
    assign w_rd        = avs.avs_chipselect && avs.avs_read && w_ch_ok;
    assign w_wdata     = avs.avs_writedata[WIDTH-1:0];
    assign w_unused_wd = ^avs.avs_writedata;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pio_channel #(
            .IS_INPUT    (CH_IS_INPUT[c]),
            .WIDTH       (WIDTH),
            .EDGE_TYPE   (EDGE_TYPE),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk       (clk_clk),
            .rst_n     (reset_reset_n),
            .i_pin     (pio_in[c*WIDTH +: WIDTH]),
            .i_wr_en   (w_wr && (w_ch == CH_W'(c))),
            .i_reg     (w_reg),
            .i_wdata   (w_wdata),
            .o_rdata_c (w_rdata[c]),
            .o_out     (pio_out[c*WIDTH +: WIDTH]),
            .o_irq_c   (w_irq[c])
        );
    end

    // Read mux sees pre-write state, so a simultaneous write returns old data.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            avs.avs_readdata <= '0;
            irq              <= 1'b0;
        end else begin
            irq              <= |w_irq;
            avs.avs_readdata <= w_rd ? 32'(w_rdata[w_ch]) : '0;
        end
    end

endmodule

// File: tb/tb_avalon_pio_bank.sv
// Directed self-checking bench: a 3-channel 16-bit rising-edge bank and a
// 16-channel 32-bit any-edge bank with a 3-stage synchroniser.
module tb_avalon_pio_bank;

    logic         clk;
    logic         rst_n;
    logic         irq_a;
    logic         irq_b;
    logic [47:0]  pio_in_a;
    logic [47:0]  pio_out_a;
    logic [511:0] pio_in_b;
    logic [511:0] pio_out_b;
    logic [31:0]  rd;

    int n_total = 0;
    int n_bad   = 0;

    avalon_pio_bank_if #(.ADDR_W(5)) bus_a ();
    avalon_pio_bank_if #(.ADDR_W(7)) bus_b ();

    avalon_pio_bank #(
        .NUM_CH(3), .WIDTH(16), .CH_IS_INPUT(3'b101), .EDGE_TYPE(0), .SYNC_STAGES(2)
    ) u_dut_a (
        .clk_clk(clk), .reset_reset_n(rst_n), .avs(bus_a),
        .irq(irq_a), .pio_in(pio_in_a), .pio_out(pio_out_a)
    );

    avalon_pio_bank #(
        .NUM_CH(16), .WIDTH(32), .CH_IS_INPUT(16'h8000), .EDGE_TYPE(2), .SYNC_STAGES(3)
    ) u_dut_b (
        .clk_clk(clk), .reset_reset_n(rst_n), .avs(bus_b),
        .irq(irq_b), .pio_in(pio_in_b), .pio_out(pio_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bus tasks are called at a negedge; the access lands on the next posedge.
    task automatic a_wr(input logic [4:0] addr, input logic [31:0] data);
        bus_a.avs_chipselect = 1'b1; bus_a.avs_write = 1'b1;
        bus_a.avs_address = addr;    bus_a.avs_writedata = data;
        @(negedge clk);
        bus_a.avs_chipselect = 1'b0; bus_a.avs_write = 1'b0;
    endtask

    task automatic a_rd(input logic [4:0] addr, output logic [31:0] data);
        bus_a.avs_chipselect = 1'b1; bus_a.avs_read = 1'b1; bus_a.avs_address = addr;
        @(negedge clk);
        data = bus_a.avs_readdata;
        bus_a.avs_chipselect = 1'b0; bus_a.avs_read = 1'b0;
    endtask

    task automatic a_rdwr(input logic [4:0] addr, input logic [31:0] wdata, output logic [31:0] data);
        bus_a.avs_chipselect = 1'b1; bus_a.avs_read = 1'b1; bus_a.avs_write = 1'b1;
        bus_a.avs_address = addr;    bus_a.avs_writedata = wdata;
        @(negedge clk);
        data = bus_a.avs_readdata;
        bus_a.avs_chipselect = 1'b0; bus_a.avs_read = 1'b0; bus_a.avs_write = 1'b0;
    endtask

    task automatic b_wr(input logic [6:0] addr, input logic [31:0] data);
        bus_b.avs_chipselect = 1'b1; bus_b.avs_write = 1'b1;
        bus_b.avs_address = addr;    bus_b.avs_writedata = data;
        @(negedge clk);
        bus_b.avs_chipselect = 1'b0; bus_b.avs_write = 1'b0;
    endtask

    task automatic b_rd(input logic [6:0] addr, output logic [31:0] data);
        bus_b.avs_chipselect = 1'b1; bus_b.avs_read = 1'b1; bus_b.avs_address = addr;
        @(negedge clk);
        data = bus_b.avs_readdata;
        bus_b.avs_chipselect = 1'b0; bus_b.avs_read = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus_a.avs_chipselect = 1'b0; bus_a.avs_read = 1'b0; bus_a.avs_write = 1'b0;
        bus_a.avs_address = '0;      bus_a.avs_writedata = '0;
        bus_b.avs_chipselect = 1'b0; bus_b.avs_read = 1'b0; bus_b.avs_write = 1'b0;
        bus_b.avs_address = '0;      bus_b.avs_writedata = '0;
        pio_in_a = 48'({$urandom(), $urandom()});
        for (int i = 0; i < 16; i++) pio_in_b[i*32 +: 32] = $urandom();

        // Reset with random pins
        tick(3);
        chk("rst_pio_a_lo", pio_out_a[31:0], 32'h0);
        chk("rst_pio_a_hi", 32'(pio_out_a[47:32]), 32'h0);
        chk("rst_pio_b_any", 32'(|pio_out_b), 32'h0);
        chk("rst_irq_a", 32'(irq_a), 32'h0);
        chk("rst_irq_b", 32'(irq_b), 32'h0);
        chk("rst_rdata_a", bus_a.avs_readdata, 32'h0);
        chk("rst_rdata_b", bus_b.avs_readdata, 32'h0);
        pio_in_a = '0;
        pio_in_b = '0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 8; r++) begin
                a_rd(5'(c*8 + r), rd);
                chk($sformatf("rst_rd_c%0d_r%0d", c, r), rd, 32'h0);
            end
        end

        // Output channel 1: DATA, SET, CLR
        a_wr(5'd8, 32'hABCD_00F0);
        chk("out_vis_data", 32'(pio_out_a[31:16]), 32'h0000_00F0);
        a_wr(5'd12, 32'h0000_0003);
        a_wr(5'd13, 32'h0000_0010);
        a_rd(5'd8, rd);
        chk("out_rd_e3", rd, 32'h0000_00E3);
        chk("out_pin_e3", 32'(pio_out_a[31:16]), 32'h0000_00E3);

        // Read+write same cycle returns pre-write value
        a_rdwr(5'd8, 32'h0000_1234, rd);
        chk("rdwr_old", rd, 32'h0000_00E3);
        a_rd(5'd8, rd);
        chk("rdwr_new", rd, 32'h0000_1234);
        bus_a.avs_write = 1'b1; bus_a.avs_address = 5'd8; bus_a.avs_writedata = 32'hFFFF;
        tick(1);
        bus_a.avs_write = 1'b0;
        a_rd(5'd8, rd);
        chk("no_cs_write", rd, 32'h0000_1234);

        // Boundaries
        a_rd(5'd24, rd);  chk("rd_ch3", rd, 32'h0);
        a_rd(5'd11, rd);  chk("rd_rsvd3", rd, 32'h0);
        a_rd(5'd14, rd);  chk("rd_rsvd6", rd, 32'h0);
        a_rd(5'd15, rd);  chk("rd_rsvd7", rd, 32'h0);
        a_wr(5'd9, 32'hFFFF);
        a_rd(5'd9, rd);   chk("out_mask_rd0", rd, 32'h0);
        a_wr(5'd0, 32'hFFFF);
        a_wr(5'd4, 32'hFFFF);
        chk("in0_pin_held0", 32'(pio_out_a[15:0]), 32'h0);
        a_wr(5'd20, 32'hFFFF);
        chk("in2_pin_held0", 32'(pio_out_a[47:32]), 32'h0);
        a_wr(5'd28, 32'hFFFF);
        a_rd(5'd8, rd);   chk("ch3_wr_ignored", rd, 32'h0000_1234);
        a_rd(5'd0, rd);   chk("in0_data_low", rd, 32'h0);

        // Input ch0 rising edge latency
        a_wr(5'd1, 32'h1);
        pio_in_a[0] = 1'b1;
        tick(3); chk("irq_k2", 32'(irq_a), 32'h0);
        tick(1); chk("irq_k3", 32'(irq_a), 32'h0);
        tick(1); chk("irq_k4", 32'(irq_a), 32'h1);
        a_rd(5'd2, rd);  chk("cap_bit0", rd, 32'h1);
        a_rd(5'd0, rd);  chk("in0_data_high", rd, 32'h1);
        a_wr(5'd2, 32'h1);
        chk("w1c_irq_lag", 32'(irq_a), 32'h1);
        tick(1); chk("w1c_irq_low", 32'(irq_a), 32'h0);
        a_rd(5'd2, rd);  chk("w1c_cap0", rd, 32'h0);

        // Capture while masked, then unmask
        a_wr(5'd1, 32'h0);
        pio_in_a[1] = 1'b1;
        tick(6); chk("masked_irq", 32'(irq_a), 32'h0);
        a_rd(5'd2, rd);  chk("masked_cap", rd, 32'h2);
        a_wr(5'd1, 32'h2);
        tick(1); chk("unmask_irq", 32'(irq_a), 32'h1);
        a_rd(5'd1, rd);  chk("mask_rd", rd, 32'h2);
        a_wr(5'd2, 32'h2);
        tick(1); chk("unmask_clr_irq", 32'(irq_a), 32'h0);

        // Collision of W1C and new edge on bit2
        a_wr(5'd1, 32'h4);
        pio_in_a[2] = 1'b1;
        tick(6);
        a_rd(5'd2, rd);  chk("coll_pre_cap", rd, 32'h4);
        chk("coll_pre_irq", 32'(irq_a), 32'h1);
        pio_in_a[2] = 1'b0;
        tick(6);
        a_rd(5'd2, rd);  chk("fall_ignored", rd, 32'h4);
        pio_in_a[2] = 1'b1;
        tick(3);
        a_wr(5'd2, 32'h4);
        chk("coll_irq0", 32'(irq_a), 32'h1);
        tick(1); chk("coll_irq1", 32'(irq_a), 32'h1);
        a_rd(5'd2, rd);  chk("coll_cap", rd, 32'h4);
        a_wr(5'd2, 32'h4);
        tick(1); chk("coll_clr_irq", 32'(irq_a), 32'h0);
        a_rd(5'd2, rd);  chk("coll_clr_cap", rd, 32'h0);

        // Second input channel feeds the same irq
        a_wr(5'd17, 32'h1);
        pio_in_a[32] = 1'b1;
        tick(6); chk("ch2_irq", 32'(irq_a), 32'h1);
        a_rd(5'd18, rd); chk("ch2_cap", rd, 32'h1);
        a_wr(5'd18, 32'h1);
        tick(1); chk("ch2_clr_irq", 32'(irq_a), 32'h0);

        // Reset during a read+write
        bus_a.avs_chipselect = 1'b1; bus_a.avs_read = 1'b1; bus_a.avs_write = 1'b1;
        bus_a.avs_address = 5'd8;    bus_a.avs_writedata = 32'hFFFF;
        rst_n = 1'b0;
        tick(1);
        chk("midrst_rdata", bus_a.avs_readdata, 32'h0);
        chk("midrst_pin", 32'(pio_out_a[31:16]), 32'h0);
        bus_a.avs_chipselect = 1'b0; bus_a.avs_read = 1'b0; bus_a.avs_write = 1'b0;
        rst_n = 1'b1;
        a_rd(5'd8, rd);  chk("midrst_data", rd, 32'h0);

        // Wide bank: 32-bit output channel 3
        b_wr(7'd28, 32'hFFFF_FFFF);
        chk("b_out_set_pin", pio_out_b[127:96], 32'hFFFF_FFFF);
        b_wr(7'd29, 32'h0000_FFFF);
        b_rd(7'd24, rd); chk("b_out_clr", rd, 32'hFFFF_0000);

        // Wide bank: pin31 of ch15, any edge, 3-stage sync
        b_wr(7'd121, 32'h8000_0000);
        pio_in_b[511] = 1'b1;
        tick(4); chk("b_irq_k3", 32'(irq_b), 32'h0);
        tick(1); chk("b_irq_k4", 32'(irq_b), 32'h0);
        tick(1); chk("b_irq_k5", 32'(irq_b), 32'h1);
        b_rd(7'd122, rd); chk("b_cap_rise", rd, 32'h8000_0000);
        b_rd(7'd120, rd); chk("b_data_high", rd, 32'h8000_0000);
        b_wr(7'd122, 32'h8000_0000);
        tick(1); chk("b_clr1_irq", 32'(irq_b), 32'h0);
        b_rd(7'd122, rd); chk("b_clr1_cap", rd, 32'h0);
        pio_in_b[511] = 1'b0;
        tick(8); chk("b_fall_irq", 32'(irq_b), 32'h1);
        b_rd(7'd122, rd); chk("b_cap_fall", rd, 32'h8000_0000);
        b_wr(7'd122, 32'h8000_0000);
        tick(1); chk("b_clr2_irq", 32'(irq_b), 32'h0);
        b_rd(7'd122, rd); chk("b_clr2_cap", rd, 32'h0);
        b_rd(7'd120, rd); chk("b_data_low", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
